// File: rtl/main_control_fsm.sv
// Multicycle datapath controller: Moore FSM sequencing fetch/decode/execute,
// memory handshake, retirement counting and illegal-opcode trap.
module main_control_fsm #(
  parameter int unsigned INSTRET_W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [6:0]           opcode,
  input  logic                 mem_ready,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 i_or_d,
  output logic                 ir_write,
  output logic                 pc_write,
  output logic                 pc_write_cond,
  output logic                 reg_write,
  output logic                 mem_to_reg,
  output logic                 alu_src_a,
  output logic                 pc_source,
  output logic [1:0]           alu_src_b,
  output logic [1:0]           aluop,
  output logic                 retire,
  output logic [INSTRET_W-1:0] instret,
  output logic                 trap,
  output logic [3:0]           state
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEM_ADDR = 4'd2,
    MEM_RD   = 4'd3,
    MEM_WB   = 4'd4,
    MEM_WR   = 4'd5,
    EXEC     = 4'd6,
    ALU_WB   = 4'd7,
    BRANCH   = 4'd8,
    TRAP     = 4'd9
  } state_e;

  state_e cur_state;
  state_e nxt_state;

  always_ff @(posedge clk) begin
    cur_state <= nxt_state;
  end

  // Next state and Moore outputs; mem_ready only qualifies strobes in wait states.
  always_comb begin
    nxt_state     = cur_state;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    i_or_d        = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    reg_write     = 1'b0;
    mem_to_reg    = 1'b0;
    alu_src_a     = 1'b0;
    pc_source     = 1'b0;
    alu_src_b     = 2'b00;
    aluop         = 2'b00;
    retire        = 1'b0;
    trap          = 1'b0;

    case (cur_state)
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        if (mem_ready) begin
          ir_write  = 1'b1;
          pc_write  = 1'b1;
          nxt_state = DECODE;
        end
      end
      DECODE: begin
        alu_src_b = 2'b10;
        case (opcode)
          OP_LOAD, OP_STORE: nxt_state = MEM_ADDR;
          OP_RTYPE:          nxt_state = EXEC;
          OP_BRANCH:         nxt_state = BRANCH;
          default:           nxt_state = TRAP;
        endcase
      end
      MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        // IR is stable across the instruction, so the opcode is simply re-read.
        nxt_state = (opcode == OP_LOAD) ? MEM_RD : MEM_WR;
      end
      MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (mem_ready) nxt_state = MEM_WB;
      end
      MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
        nxt_state  = FETCH;
      end
      MEM_WR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        if (mem_ready) begin
          retire    = 1'b1;
          nxt_state = FETCH;
        end
      end
      EXEC: begin
        alu_src_a = 1'b1;
        aluop     = 2'b10;
        nxt_state = ALU_WB;
      end
      ALU_WB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        nxt_state = FETCH;
      end
      BRANCH: begin
        alu_src_a     = 1'b1;
        aluop         = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 1'b1;
        retire        = 1'b1;
        nxt_state     = FETCH;
      end
      TRAP: begin
        trap      = 1'b1;
        nxt_state = TRAP;
      end
      default: nxt_state = FETCH;
    endcase

    // Reset suppresses every architectural side effect of the current cycle.
    if (reset) begin
      ir_write      = 1'b0;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      reg_write     = 1'b0;
      mem_write     = 1'b0;
      retire        = 1'b0;
      nxt_state     = FETCH;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      instret <= '0;
    end else if (retire) begin
      instret <= instret + INSTRET_W'(1);
    end
  end

  assign state = cur_state;

endmodule

// File: tb/tb_main_control_fsm.sv
// Scoreboard bench for main_control_fsm: instruction-level reference model
// pushes per-cycle expectations, a negedge monitor pops and compares.
module tb_main_control_fsm;

  logic       clk;
  logic       reset;
  logic [6:0] opcode;
  logic       mem_ready;

  logic        mem_read, mem_write, i_or_d, ir_write, pc_write, pc_write_cond;
  logic        reg_write, mem_to_reg, alu_src_a, pc_source, retire, trap;
  logic [1:0]  alu_src_b, aluop;
  logic [31:0] instret;
  logic [3:0]  state;

  logic        mem_read4, mem_write4, i_or_d4, ir_write4, pc_write4, pc_write_cond4;
  logic        reg_write4, mem_to_reg4, alu_src_a4, pc_source4, retire4, trap4;
  logic [1:0]  alu_src_b4, aluop4;
  logic [3:0]  instret4;
  logic [3:0]  state4;

  main_control_fsm dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .mem_read(mem_read), .mem_write(mem_write), .i_or_d(i_or_d),
    .ir_write(ir_write), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
    .reg_write(reg_write), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
    .pc_source(pc_source), .alu_src_b(alu_src_b), .aluop(aluop),
    .retire(retire), .instret(instret), .trap(trap), .state(state)
  );

  main_control_fsm #(.INSTRET_W(4)) dut4 (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .mem_read(mem_read4), .mem_write(mem_write4), .i_or_d(i_or_d4),
    .ir_write(ir_write4), .pc_write(pc_write4), .pc_write_cond(pc_write_cond4),
    .reg_write(reg_write4), .mem_to_reg(mem_to_reg4), .alu_src_a(alu_src_a4),
    .pc_source(pc_source4), .alu_src_b(alu_src_b4), .aluop(aluop4),
    .retire(retire4), .instret(instret4), .trap(trap4), .state(state4)
  );

  typedef struct packed {
    logic [3:0] st;
    logic       mem_read, mem_write, i_or_d, ir_write, pc_write, pc_write_cond;
    logic       reg_write, mem_to_reg, alu_src_a, pc_source;
    logic [1:0] alu_src_b, aluop;
    logic       retire, trap;
  } row_t;

  typedef struct packed {
    row_t        row;
    logic [31:0] cnt;
  } item_t;

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] BEQ = 7'b1100011;
  localparam logic [6:0] ILL = 7'b1111111;

  item_t       q[$];
  logic [31:0] model_cnt;
  int          tests;
  int          fails;
  int          cycle_no;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output table per state, as listed in the control description.
  function automatic row_t exp_row(input int st, input logic mr, input logic rst);
    row_t r;
    r = '0;
    r.st = 4'(st);
    case (st)
      0: begin r.mem_read = 1'b1; r.alu_src_b = 2'b01; r.ir_write = mr; r.pc_write = mr; end
      1: r.alu_src_b = 2'b10;
      2: begin r.alu_src_a = 1'b1; r.alu_src_b = 2'b10; end
      3: begin r.mem_read = 1'b1; r.i_or_d = 1'b1; end
      4: begin r.reg_write = 1'b1; r.mem_to_reg = 1'b1; r.retire = 1'b1; end
      5: begin r.mem_write = 1'b1; r.i_or_d = 1'b1; r.retire = mr; end
      6: begin r.alu_src_a = 1'b1; r.aluop = 2'b10; end
      7: begin r.reg_write = 1'b1; r.retire = 1'b1; end
      8: begin
        r.alu_src_a = 1'b1; r.aluop = 2'b01; r.pc_write_cond = 1'b1;
        r.pc_source = 1'b1; r.retire = 1'b1;
      end
      9: r.trap = 1'b1;
      default: r = '0;
    endcase
    if (rst) begin
      r.ir_write = 1'b0; r.pc_write = 1'b0; r.pc_write_cond = 1'b0;
      r.reg_write = 1'b0; r.mem_write = 1'b0; r.retire = 1'b0;
    end
    return r;
  endfunction

  // One clock of stimulus: the expected row for this cycle is queued first.
  task automatic cyc(input int st, input logic mr, input logic rst);
    item_t it;
    reset     = rst;
    mem_ready = mr;
    it.row = exp_row(st, mr, rst);
    it.cnt = model_cnt;
    q.push_back(it);
    if (rst) model_cnt = '0;
    else if (it.row.retire) model_cnt = model_cnt + 32'd1;
    @(posedge clk);
    #1;
  endtask

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  // Expected state trace of one instruction, built from its class and stall counts.
  task automatic instr(input logic [6:0] op, input int fs, input int ms);
    opcode = op;
    for (int i = 0; i < fs; i++) cyc(0, 1'b0, 1'b0);
    cyc(0, 1'b1, 1'b0);
    cyc(1, rnd(), 1'b0);
    case (op)
      LW: begin
        cyc(2, rnd(), 1'b0);
        for (int i = 0; i < ms; i++) cyc(3, 1'b0, 1'b0);
        cyc(3, 1'b1, 1'b0);
        cyc(4, rnd(), 1'b0);
      end
      SW: begin
        cyc(2, rnd(), 1'b0);
        for (int i = 0; i < ms; i++) cyc(5, 1'b0, 1'b0);
        cyc(5, 1'b1, 1'b0);
      end
      RT: begin
        cyc(6, rnd(), 1'b0);
        cyc(7, rnd(), 1'b0);
      end
      BEQ: cyc(8, rnd(), 1'b0);
      default: for (int i = 0; i < 20; i++) cyc(9, rnd(), 1'b0);
    endcase
  endtask

  row_t act_row, act_row4;
  assign act_row  = '{state, mem_read, mem_write, i_or_d, ir_write, pc_write, pc_write_cond,
                      reg_write, mem_to_reg, alu_src_a, pc_source, alu_src_b, aluop, retire, trap};
  assign act_row4 = '{state4, mem_read4, mem_write4, i_or_d4, ir_write4, pc_write4, pc_write_cond4,
                      reg_write4, mem_to_reg4, alu_src_a4, pc_source4, alu_src_b4, aluop4,
                      retire4, trap4};

  // Monitor: one queued expectation per cycle, checked mid-cycle.
  always @(negedge clk) begin
    item_t it;
    if (q.size() > 0) begin
      it = q.pop_front();
      cycle_no++;
      tests++;
      if (act_row !== it.row) begin
        fails++;
        $display("FAIL outputs cycle %0d: got %h expected %h (state got %0d exp %0d)",
                 cycle_no, act_row, it.row, act_row.st, it.row.st);
      end
      tests++;
      if (instret !== it.cnt) begin
        fails++;
        $display("FAIL instret cycle %0d: got %0d expected %0d", cycle_no, instret, it.cnt);
      end
      tests++;
      if (act_row4 !== it.row || instret4 !== it.cnt[3:0]) begin
        fails++;
        $display("FAIL narrow_dut cycle %0d: got %h/%0d expected %h/%0d",
                 cycle_no, act_row4, instret4, it.row, it.cnt[3:0]);
      end
    end
  end

  initial begin
    int   kind;
    logic [6:0] ops[4];
    ops[0] = LW; ops[1] = SW; ops[2] = RT; ops[3] = BEQ;
    tests = 0; fails = 0; cycle_no = 0;
    model_cnt = '0;
    reset = 1'b1; mem_ready = 1'b0; opcode = RT;
    repeat (2) @(posedge clk);
    #1;
    cyc(0, 1'b0, 1'b1);

    // R-type, no stalls
    instr(RT, 0, 0);
    // lw with 3 fetch stalls and 2 read stalls
    instr(LW, 3, 2);
    // sw then beq back to back
    instr(SW, 0, 0);
    instr(BEQ, 0, 0);
    // illegal opcode traps until reset
    instr(ILL, 0, 0);
    cyc(9, 1'b1, 1'b1);
    // reset while waiting in MEM_RD
    opcode = LW;
    cyc(0, 1'b1, 1'b0);
    cyc(1, 1'b0, 1'b0);
    cyc(2, 1'b0, 1'b0);
    cyc(3, 1'b0, 1'b0);
    cyc(3, 1'b0, 1'b1);
    // 16 R-types wrap the narrow counter
    for (int i = 0; i < 16; i++) instr(RT, 0, 0);
    // randomized mix
    for (int i = 0; i < 60; i++) begin
      kind = int'($urandom_range(0, 3));
      instr(ops[kind], int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end
    // reset while waiting in MEM_WR
    opcode = SW;
    cyc(0, 1'b1, 1'b0);
    cyc(1, 1'b0, 1'b0);
    cyc(2, 1'b0, 1'b0);
    cyc(5, 1'b0, 1'b0);
    cyc(5, 1'b1, 1'b1);
    cyc(0, 1'b0, 1'b0);

    for (int i = 0; i < 4 && q.size() > 0; i++) @(negedge clk);
    #1;
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
